// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - display data in / board pin out bundle for the segment scanner
//
// Groups the per-digit display data coming from the datapath and the
// multiplexed board-pin outputs.
//   master : the datapath side; drives digit data and scan controls, observes pins
//   slave  : the scanner; consumes digit data, drives AN/SEG/DP and status
// Signals:
//   digits_i    hex nibble per digit, digit k = bits [4k+3:4k]
//   dp_i        decimal point request per digit (1 = lit)
//   en_mask_i   digit enable (0 = skipped in scan)
//   lz_en_i     leading-zero suppression enable
//   div_i       digit on-time minus one, in clock cycles
//   AN          anode select, active-low one-hot
//   SEG         segments {g,f,e,d,c,b,a}, active-low
//   DP          decimal point, active-low
//   digit_sel_o index of the digit currently driven
//   frame_o     one-cycle pulse when the scan wraps
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_WIDTH  = 16
);
    localparam int SEL_W = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   en_mask_i;
    logic                    lz_en_i;
    logic [DIV_WIDTH-1:0]    div_i;
    logic [NUM_DIGITS-1:0]   AN;
    logic [6:0]              SEG;
    logic                    DP;
    logic [SEL_W-1:0]        digit_sel_o;
    logic                    frame_o;

    modport master (
        output digits_i, dp_i, en_mask_i, lz_en_i, div_i,
        input  AN, SEG, DP, digit_sel_o, frame_o
    );

    modport slave (
        input  digits_i, dp_i, en_mask_i, lz_en_i, div_i,
        output AN, SEG, DP, digit_sel_o, frame_o
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed common-anode 7-segment display scanner
//
// Time-multiplexes NUM_DIGITS hex digits onto one shared segment bus with a
// programmable on-time, per-digit enable mask, dead time between digits,
// decimal points, leading-zero suppression and built-in hex decode.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  seg_scan_ctrl_if.slave: digit data/controls in, AN/SEG/DP/status out
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int DIV_WIDTH   = 16,
    parameter int DEAD_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int DC_W  = $clog2(DEAD_CYCLES + 2);
    localparam logic [DC_W-1:0] DEAD_LAST =
        (DEAD_CYCLES > 0) ? DC_W'(DEAD_CYCLES - 1) : '0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_req;
    logic [NUM_DIGITS-1:0]   en_mask;
    logic                    lz_en;
    logic [DIV_WIDTH-1:0]    div_in;

    assign digits  = bus.digits_i;
    assign dp_req  = bus.dp_i;
    assign en_mask = bus.en_mask_i;
    assign lz_en   = bus.lz_en_i;
    assign div_in  = bus.div_i;

    state_t                 state;
    logic [SEL_W-1:0]       sel;
    logic [SEL_W-1:0]       pend_idx;
    logic [DIV_WIDTH-1:0]   presc;
    logic [DIV_WIDTH-1:0]   div_lat;
    logic [DC_W-1:0]        dead_cnt;
    logic [NUM_DIGITS-1:0]  an_r;
    logic [6:0]             seg_r;
    logic                   dp_r;
    logic                   frame_r;

    // Lowest enabled index (IDLE exit) and first enabled index after sel in
    // circular order. The descending loop lets the nearest candidate win; when
    // sel is the only enabled digit the full-circle candidate (sel) is chosen.
    logic [SEL_W-1:0] first_idx;
    logic [SEL_W-1:0] next_idx;
    always_comb begin
        first_idx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (en_mask[i]) first_idx = SEL_W'(i);
        end
        next_idx = sel;
        for (int i = NUM_DIGITS; i >= 1; i--) begin
            if (en_mask[SEL_W'((int'(sel) + i) % NUM_DIGITS)])
                next_idx = SEL_W'((int'(sel) + i) % NUM_DIGITS);
        end
    end

    logic show_last;
    logic dead_done;
    assign show_last = (presc == div_lat);
    assign dead_done = (dead_cnt == DEAD_LAST);

    // Decide whether this edge enters SHOW, on which index, and whether that
    // entry counts as a scan wrap.
    logic             do_enter;
    logic             enter_frame;
    logic [SEL_W-1:0] entry_idx;
    always_comb begin
        do_enter    = 1'b0;
        enter_frame = 1'b0;
        entry_idx   = pend_idx;
        case (state)
            IDLE: begin
                entry_idx = first_idx;
                do_enter  = |en_mask;
            end
            SHOW: begin
                entry_idx = next_idx;
                if (show_last && (|en_mask) && (DEAD_CYCLES == 0)) begin
                    do_enter    = 1'b1;
                    enter_frame = (next_idx <= sel);
                end
            end
            BLANK: begin
                entry_idx = pend_idx;
                if (dead_done) begin
                    do_enter    = 1'b1;
                    enter_frame = (pend_idx <= sel);
                end
            end
            default: ;
        endcase
    end

    // Value latched for the digit being entered. A zero digit is suppressed
    // when no enabled digit above it is non-zero; since a suppressed digit is
    // itself zero, "0 or suppressed" reduces to "0".
    logic [3:0]            entry_nib;
    logic                  entry_dp;
    logic                  nz_above;
    logic                  entry_sup;
    logic [NUM_DIGITS-1:0] entry_an;
    always_comb begin
        entry_nib = 4'h0;
        entry_dp  = 1'b0;
        nz_above  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (SEL_W'(k) == entry_idx) begin
                entry_nib = digits[4*k +: 4];
                entry_dp  = dp_req[k];
            end
            if ((k > int'(entry_idx)) && en_mask[k] && (digits[4*k +: 4] != 4'h0))
                nz_above = 1'b1;
        end
        entry_sup = lz_en && (entry_nib == 4'h0) && (entry_idx != '0) && !nz_above;
        entry_an  = ~(NUM_DIGITS'(1) << entry_idx);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sel      <= '0;
            pend_idx <= '0;
            presc    <= '0;
            div_lat  <= '0;
            dead_cnt <= '0;
            an_r     <= AN_OFF;
            seg_r    <= 7'h7F;
            dp_r     <= 1'b1;
            frame_r  <= 1'b0;
        end else begin
            frame_r <= 1'b0;
            if (do_enter) begin
                state   <= SHOW;
                sel     <= entry_idx;
                presc   <= '0;
                div_lat <= div_in;
                an_r    <= entry_an;
                seg_r   <= entry_sup ? 7'h7F : hex_to_seg(entry_nib);
                dp_r    <= ~entry_dp;
                frame_r <= enter_frame;
            end else begin
                case (state)
                    IDLE: begin
                        an_r  <= AN_OFF;
                        seg_r <= 7'h7F;
                        dp_r  <= 1'b1;
                    end
                    SHOW: begin
                        if (show_last) begin
                            // Mask is re-evaluated here: an empty mask ends the
                            // scan after the current digit completes.
                            state    <= (|en_mask) ? BLANK : IDLE;
                            pend_idx <= next_idx;
                            dead_cnt <= '0;
                            an_r     <= AN_OFF;
                            seg_r    <= 7'h7F;
                            dp_r     <= 1'b1;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    BLANK: begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.AN          = an_r;
    assign bus.SEG         = seg_r;
    assign bus.DP          = dp_r;
    assign bus.digit_sel_o = sel;
    assign bus.frame_o     = frame_r;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4*ND-1:0] t_digits;
    logic [ND-1:0]   t_dp;
    logic [ND-1:0]   t_mask;
    logic            t_lz;
    logic [DW-1:0]   t_div;

    seg_scan_ctrl_if #(.NUM_DIGITS(ND), .DIV_WIDTH(DW)) bus_a ();
    seg_scan_ctrl_if #(.NUM_DIGITS(ND), .DIV_WIDTH(DW)) bus_b ();

    assign bus_a.digits_i  = t_digits;
    assign bus_a.dp_i      = t_dp;
    assign bus_a.en_mask_i = t_mask;
    assign bus_a.lz_en_i   = t_lz;
    assign bus_a.div_i     = t_div;
    assign bus_b.digits_i  = t_digits;
    assign bus_b.dp_i      = t_dp;
    assign bus_b.en_mask_i = t_mask;
    assign bus_b.lz_en_i   = t_lz;
    assign bus_b.div_i     = t_div;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV_WIDTH(DW), .DEAD_CYCLES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV_WIDTH(DW), .DEAD_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: the display as a schedule of "digit k lit for N more
    // cycles" / "dark for N more cycles" slots, with expected pin values.
    typedef struct {
        bit running;
        int cur;
        int on_left;
        int gap_left;
        int pend;
        int an;
        int seg;
        int dp;
        int sel;
        int frame;
    } mdl_t;

    mdl_t ma, mb;

    int seg_tab [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                         'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};

    function automatic int nib(int k);
        return int'((t_digits >> (4 * k)) & 16'hF);
    endfunction

    function automatic int lowest();
        for (int j = 0; j < ND; j++) if (t_mask[j]) return j;
        return 0;
    endfunction

    function automatic int next_after(int c);
        for (int d = 1; d <= ND; d++) if (t_mask[(c + d) % ND]) return (c + d) % ND;
        return c;
    endfunction

    function automatic mdl_t dark(mdl_t m);
        m.an  = (1 << ND) - 1;
        m.seg = 'h7F;
        m.dp  = 1;
        return m;
    endfunction

    function automatic mdl_t mreset();
        mdl_t m;
        m = '{default: 0};
        m = dark(m);
        return m;
    endfunction

    function automatic mdl_t show(mdl_t m, int k, int fr);
        bit sup;
        sup = t_lz && (nib(k) == 0) && (k > 0);
        for (int j = k + 1; j < ND; j++) if (t_mask[j] && nib(j) != 0) sup = 0;
        m.running  = 1;
        m.cur      = k;
        m.on_left  = int'(t_div) + 1;
        m.gap_left = 0;
        m.an       = ((1 << ND) - 1) & ~(1 << k);
        m.seg      = sup ? 'h7F : seg_tab[nib(k)];
        m.dp       = t_dp[k] ? 0 : 1;
        m.sel      = k;
        m.frame    = fr;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, int dead);
        int n;
        m.frame = 0;
        if (!m.running) begin
            if (t_mask != 0) m = show(m, lowest(), 0);
        end else if (m.on_left > 1) begin
            m.on_left--;
        end else if (m.on_left == 1) begin
            m.on_left = 0;
            if (t_mask == 0) begin
                m = dark(m);
                m.running = 0;
            end else begin
                n = next_after(m.cur);
                if (dead == 0) m = show(m, n, (n <= m.cur) ? 1 : 0);
                else begin
                    m = dark(m);
                    m.gap_left = dead;
                    m.pend = n;
                end
            end
        end else begin
            m.gap_left--;
            if (m.gap_left == 0) m = show(m, m.pend, (m.pend <= m.cur) ? 1 : 0);
        end
        return m;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = step(ma, 2);
            mb = step(mb, 0);
        end
    end

    task automatic check_outputs();
        chk("a_an",    32'(bus_a.AN),          ma.an);
        chk("a_seg",   32'(bus_a.SEG),         ma.seg);
        chk("a_dp",    32'(bus_a.DP),          ma.dp);
        chk("a_sel",   32'(bus_a.digit_sel_o), ma.sel);
        chk("a_frame", 32'(bus_a.frame_o),     ma.frame);
        chk("b_an",    32'(bus_b.AN),          mb.an);
        chk("b_seg",   32'(bus_b.SEG),         mb.seg);
        chk("b_dp",    32'(bus_b.DP),          mb.dp);
        chk("b_sel",   32'(bus_b.digit_sel_o), mb.sel);
        chk("b_frame", 32'(bus_b.frame_o),     mb.frame);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            check_outputs();
        end
    endtask

    initial begin
        t_digits = 16'h1234;
        t_dp     = '0;
        t_mask   = 4'hF;
        t_lz     = 1'b0;
        t_div    = 8'd3;
        #1 rst = 1'b0;
        cyc(3);
        rst = 1'b1;

        cyc(40);
        t_mask = 4'b0101;
        cyc(30);
        t_mask = 4'hF; t_lz = 1'b1; t_digits = 16'h0070; t_dp = 4'b0010;
        cyc(30);
        t_mask = 4'h0;
        cyc(15);
        t_mask = 4'b1000;
        cyc(20);
        t_mask = 4'hF; t_div = 8'd0;
        cyc(20);
        t_div = 8'd3; t_digits = 16'h8A5F;
        cyc(13);

        #2 rst = 1'b0;
        #1;
        chk("arst_an",  32'(bus_a.AN),  32'hF);
        chk("arst_seg", 32'(bus_a.SEG), 32'h7F);
        chk("arst_dp",  32'(bus_a.DP),  32'h1);
        chk("arst_b_an", 32'(bus_b.AN), 32'hF);
        cyc(2);
        rst = 1'b1;
        cyc(12);

        for (int ep = 0; ep < 25; ep++) begin
            t_digits = 16'($urandom);
            t_dp     = 4'($urandom);
            t_mask   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            t_lz     = 1'($urandom);
            t_div    = 8'($urandom_range(0, 4));
            repeat (60) begin
                cyc(1);
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 4))
                        0: t_digits = 16'($urandom);
                        1: t_dp     = 4'($urandom);
                        2: t_mask   = 4'($urandom);
                        3: t_lz     = ~t_lz;
                        default: t_div = 8'($urandom_range(0, 4));
                    endcase
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
